// File: rtl/uart_rx_if.sv
// Serial-in / frame-out bundle between the board RX pin and the UART receiver.
//   i_rx_data     : asynchronous serial line, idles high
//   o_data_trama  : last received data word
//   o_rx_done     : one-clock pulse per completed frame
//   o_frame_error : stop bit of last completed frame sampled low
//   o_rx_busy     : receiver is inside a frame
// master = receiver side, slave = line driver / frame consumer side.
interface uart_rx_if #(
    parameter int unsigned SIZE_TRAMA = 8
);
    logic                  i_rx_data;
    logic [SIZE_TRAMA-1:0] o_data_trama;
    logic                  o_rx_done;
    logic                  o_frame_error;
    logic                  o_rx_busy;

    modport master (
        input  i_rx_data,
        output o_data_trama,
        output o_rx_done,
        output o_frame_error,
        output o_rx_busy
    );

    modport slave (
        output i_rx_data,
        input  o_data_trama,
        input  o_rx_done,
        input  o_frame_error,
        input  o_rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 16x oversampling, mid-bit sampling, stop-bit framing check.
//   i_clk   : system clock, all logic on posedge
//   i_reset : synchronous active-high reset
//   rx_if   : serial line in, received word / done pulse / framing error / busy out
module uart_rx #(
    parameter int unsigned CLK_FR     = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned SIZE_TRAMA = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    uart_rx_if.master  rx_if
);

    localparam int unsigned DIV   = CLK_FR / (BAUD_RATE * 16);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned N_W   = (SIZE_TRAMA > 1) ? $clog2(SIZE_TRAMA) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Two-flop synchronizer; idles high so reset does not look like a start edge
    logic rx_meta;
    logic rx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
        end else begin
            rx_meta <= rx_if.i_rx_data;
            rx      <= rx_meta;
        end
    end

    // Free-running 16x baud tick, independent of FSM state
    logic [DIV_W-1:0] div_cnt;
    logic             tick_c;

    assign tick_c = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_cnt <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Frame FSM state and datapath registers
    state_t                state,   state_n;
    logic [3:0]            s_cnt,   s_cnt_n;
    logic [N_W-1:0]        n_cnt,   n_cnt_n;
    logic [SIZE_TRAMA-1:0] shreg,   shreg_n;
    logic [SIZE_TRAMA-1:0] data_q,  data_n;
    logic                  ferr_q,  ferr_n;
    logic                  done_q,  done_n;
    logic                  busy_q,  busy_n;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            s_cnt  <= '0;
            n_cnt  <= '0;
            shreg  <= '0;
            data_q <= '0;
            ferr_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            s_cnt  <= s_cnt_n;
            n_cnt  <= n_cnt_n;
            shreg  <= shreg_n;
            data_q <= data_n;
            ferr_q <= ferr_n;
            done_q <= done_n;
            busy_q <= busy_n;
        end
    end

    // Next-state and output logic; everything advances only on a tick
    always_comb begin
        state_n = state;
        s_cnt_n = s_cnt;
        n_cnt_n = n_cnt;
        shreg_n = shreg;
        data_n  = data_q;
        ferr_n  = ferr_q;
        done_n  = 1'b0;

        if (tick_c) begin
            case (state)
                IDLE: begin
                    if (!rx) begin
                        state_n = START;
                        s_cnt_n = '0;
                    end
                end
                // Re-check the line half a bit in; a high line means it was a glitch
                START: begin
                    if (s_cnt == 4'd7) begin
                        if (!rx) begin
                            state_n = DATA;
                            s_cnt_n = '0;
                            n_cnt_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
                // LSB arrives first, so shift right with the new bit entering at the MSB
                DATA: begin
                    if (s_cnt == 4'd15) begin
                        shreg_n = {rx, shreg[SIZE_TRAMA-1:1]};
                        s_cnt_n = '0;
                        if (n_cnt == N_W'(SIZE_TRAMA - 1)) begin
                            state_n = STOP;
                        end else begin
                            n_cnt_n = n_cnt + N_W'(1);
                        end
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
                // Leave at mid stop bit so a back-to-back start edge is not missed
                STOP: begin
                    if (s_cnt == 4'd15) begin
                        data_n  = shreg;
                        ferr_n  = ~rx;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Busy register tracks the state register exactly
    assign busy_n = (state_n != IDLE);

    assign rx_if.o_data_trama  = data_q;
    assign rx_if.o_frame_error = ferr_q;
    assign rx_if.o_rx_done     = done_q;
    assign rx_if.o_rx_busy     = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed vector table, hand-written corner
// sequences (glitch, mid-frame reset, line stuck low) and random frames.
module tb_uart_rx;

    localparam int unsigned CLK_FR     = 640000;
    localparam int unsigned BAUD_RATE  = 10000;
    localparam int unsigned SIZE_TRAMA = 8;
    localparam int          DIV        = 4;          // 640000 / (10000*16)
    localparam int          BIT        = 16 * DIV;   // clocks per bit

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;

    uart_rx_if #(.SIZE_TRAMA(SIZE_TRAMA)) rx_if ();

    uart_rx #(
        .CLK_FR    (CLK_FR),
        .BAUD_RATE (BAUD_RATE),
        .SIZE_TRAMA(SIZE_TRAMA)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .rx_if  (rx_if)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic       busy;
    } obs_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         pm;        // bit-period error in per-mille
        int         gap;       // idle bits after the frame
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    obs_t obs_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: decode a 10-level line image (start, 8 data LSB first, stop)
    function automatic obs_t ref_decode(input logic [9:0] line);
        obs_t r;
        int   v;
        v = 0;
        for (int i = 0; i < 8; i++) v = v + (int'(line[i+1]) << i);
        r.data = 8'(v);
        r.err  = (line[9] == 1'b0);
        r.busy = 1'b0;
        return r;
    endfunction

    task automatic idle_bits(input int nb);
        rx_if.i_rx_data = 1'b1;
        repeat (nb * BIT) @(negedge i_clk);
    endtask

    // Drive one frame; a low stop bit is released after 12/16 of the bit so the
    // idle line that follows is not read as a new start. abort_bit >= 0 returns
    // in the middle of that frame bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int pm, input int abort_bit);
        logic [9:0] bits;
        int         el;
        int         t_end;
        int         t_lo;
        bits = {stop, d, 1'b0};
        el   = 0;
        for (int k = 0; k < 10; k++) begin
            t_end = ((k + 1) * BIT * (1000 + pm)) / 1000;
            rx_if.i_rx_data = bits[k];
            if (k == abort_bit) begin
                repeat ((t_end - el) / 2) @(negedge i_clk);
                return;
            end
            if (k == 9 && !stop) begin
                t_lo = el + ((t_end - el) * 12) / 16;
                repeat (t_lo - el) @(negedge i_clk);
                el = t_lo;
                rx_if.i_rx_data = 1'b1;
            end
            repeat (t_end - el) @(negedge i_clk);
            el = t_end;
        end
    endtask

    task automatic check_pop(input string name, input logic [7:0] ed, input logic ee);
        obs_t o;
        for (int i = 0; i < 8 * BIT && obs_q.size() == 0; i++) @(negedge i_clk);
        chk({name, ".pulse"}, 32'(obs_q.size() != 0), 32'd1);
        if (obs_q.size() == 0) return;
        o = obs_q.pop_front();
        chk({name, ".data"}, 32'(o.data), 32'(ed));
        chk({name, ".err"},  32'(o.err),  32'(ee));
        chk({name, ".busy"}, 32'(o.busy), 32'd0);
    endtask

    initial begin
        vec_t       vecs[7];
        obs_t       o;
        logic [7:0] d;
        logic       stop;
        int         pm;
        int         gap;

        vecs[0] = '{data:8'hA5, stop:1'b1, pm:0,   gap:1, exp_data:8'hA5, exp_err:1'b0};
        vecs[1] = '{data:8'h3C, stop:1'b0, pm:0,   gap:1, exp_data:8'h3C, exp_err:1'b1};
        vecs[2] = '{data:8'h55, stop:1'b1, pm:0,   gap:1, exp_data:8'h55, exp_err:1'b0};
        vecs[3] = '{data:8'h00, stop:1'b1, pm:0,   gap:0, exp_data:8'h00, exp_err:1'b0};
        vecs[4] = '{data:8'hFF, stop:1'b1, pm:0,   gap:1, exp_data:8'hFF, exp_err:1'b0};
        vecs[5] = '{data:8'h5A, stop:1'b1, pm:20,  gap:1, exp_data:8'h5A, exp_err:1'b0};
        vecs[6] = '{data:8'h5A, stop:1'b1, pm:-20, gap:1, exp_data:8'h5A, exp_err:1'b0};

        fork
            forever begin
                @(negedge i_clk);
                if (rx_if.o_rx_done === 1'b1) begin
                    o.data = rx_if.o_data_trama;
                    o.err  = rx_if.o_frame_error;
                    o.busy = rx_if.o_rx_busy;
                    obs_q.push_back(o);
                end
            end
            begin
                #2ms;
                $display("FAIL watchdog: got timeout, expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        rx_if.i_rx_data = 1'b1;
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        chk("reset.data", 32'(rx_if.o_data_trama),  32'd0);
        chk("reset.done", 32'(rx_if.o_rx_done),     32'd0);
        chk("reset.ferr", 32'(rx_if.o_frame_error), 32'd0);
        chk("reset.busy", 32'(rx_if.o_rx_busy),     32'd0);
        idle_bits(1);

        // Directed frame table
        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].pm, -1);
            check_pop($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_err);
            idle_bits(vecs[i].gap);
        end

        // Short start glitch: 4 ticks low
        rx_if.i_rx_data = 1'b0;
        repeat (4 * DIV) @(negedge i_clk);
        rx_if.i_rx_data = 1'b1;
        idle_bits(2);
        chk("glitch.pulses", 32'(obs_q.size()),           32'd0);
        chk("glitch.data",   32'(rx_if.o_data_trama),     32'h5A);
        chk("glitch.busy",   32'(rx_if.o_rx_busy),        32'd0);

        // Reset during data bit 4 of 0x96, then a clean 0x81
        send_frame(8'h96, 1'b1, 0, 5);
        chk("abort.busy_before", 32'(rx_if.o_rx_busy), 32'd1);
        i_reset = 1'b1;
        rx_if.i_rx_data = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        chk("abort.data", 32'(rx_if.o_data_trama), 32'd0);
        chk("abort.busy", 32'(rx_if.o_rx_busy),    32'd0);
        idle_bits(2);
        chk("abort.pulses", 32'(obs_q.size()), 32'd0);
        send_frame(8'h81, 1'b1, 0, -1);
        check_pop("after_abort", 8'h81, 1'b0);
        idle_bits(1);

        // Line stuck low: two 0x00 frames with framing error within ~2.5 frames
        rx_if.i_rx_data = 1'b0;
        repeat (1500) @(negedge i_clk);
        rx_if.i_rx_data = 1'b1;
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        chk("stuck.pulses", 32'(obs_q.size()), 32'd2);
        check_pop("stuck0", 8'h00, 1'b1);
        check_pop("stuck1", 8'h00, 1'b1);
        chk("stuck.ferr_reset", 32'(rx_if.o_frame_error), 32'd0);
        idle_bits(1);

        // Random frames against the line-image reference
        for (int r = 0; r < 20; r++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            pm   = stop ? (int'($urandom_range(0, 40)) - 20) : 0;
            gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            o    = ref_decode({stop, d, 1'b0});
            send_frame(d, stop, pm, -1);
            check_pop($sformatf("rand%0d", r), o.data, o.err);
            idle_bits(gap);
        end

        idle_bits(2);
        chk("no_extra_pulses", 32'(obs_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
